soqpsk_mod_sequencer: RTL and testbench

SOQPSK_MOD_SEQUENCER -- requirements
Module: soqpsk_mod_sequencer

---
 rtl/soqpsk_mod_sequencer.sv | 134 +++++++++++++
 tb/tb_soqpsk_mod_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soqpsk_mod_sequencer.sv
// SOQPSK modulator sequencer: bit-rate timing, IDLE/FLUSH/RUN/DRAIN control, ternary symbol output.
// Define SOQPSK_PRECODE_EN for the SOQPSK precoder; otherwise binary OQPSK symbols (+1/-1) are emitted.
module soqpsk_mod_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] bitrateDivider,
    input  logic        modData,
    input  logic        modDataValid,
    input  logic        clrStatus,
    output logic        modClkOut,
    output logic        firNd,
    output logic [2:0]  firSym,
    output logic        running,
    output logic        underflow
);
    typedef enum logic [1:0] {IDLE, FLUSH, RUN, DRAIN} stateT;

    localparam logic [2:0] SYM_POS = 3'b001;
    localparam logic [2:0] SYM_NEG = 3'b111;

    stateT       state;
    logic [15:0] count;
    logic [15:0] reloadVal;
    logic [2:0]  symCount;
    logic        tick;
    logic        symTick;
    logic [2:0]  dataSym;
`ifdef SOQPSK_PRECODE_EN
    logic        aPrev1;
    logic        aPrev2;
    logic        parity;
`endif

    always_comb begin
        reloadVal = (bitrateDivider == '0) ? 16'd1 : bitrateDivider;
        tick      = (state != IDLE) && (count == '0);
        symTick   = tick && !modClkOut;
    end

    always_comb begin
        dataSym = modData ? SYM_POS : SYM_NEG;
`ifdef SOQPSK_PRECODE_EN
        // With +1 stored as 1, the sign of alpha reduces to parity ^ a[k-1] ^ a[k].
        if (modData == aPrev2)
            dataSym = '0;
        else
            dataSym = (parity ^ aPrev1 ^ modData) ? SYM_POS : SYM_NEG;
`endif
    end

`ifdef SOQPSK_PRECODE_EN
    // History only matters in RUN; holding it at -1,-1 / k=0 elsewhere gives the FLUSH entry values.
    always_ff @(posedge clk) begin
        if (!reset || state != RUN) begin
            aPrev1 <= 1'b0;
            aPrev2 <= 1'b0;
            parity <= 1'b0;
        end else if (symTick && enable && modDataValid) begin
            aPrev2 <= aPrev1;
            aPrev1 <= modData;
            parity <= !parity;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= bitrateDivider;
            symCount  <= '0;
            modClkOut <= 1'b0;
            firNd     <= 1'b0;
            firSym    <= '0;
            running   <= 1'b0;
            underflow <= 1'b0;
        end else begin
            firNd <= tick;
            if (tick) begin
                count     <= reloadVal;
                modClkOut <= !modClkOut;
            end else if (state != IDLE) begin
                count <= count - 16'd1;
            end
            if (clrStatus)
                underflow <= 1'b0;

            case (state)
                IDLE: begin
                    count     <= bitrateDivider;
                    modClkOut <= 1'b0;
                    firSym    <= '0;
                    symCount  <= '0;
                    running   <= 1'b0;
                    if (enable)
                        state <= FLUSH;
                end
                FLUSH, RUN: begin
                    if (!enable) begin
                        // A symbol tick coinciding with the drop is the first drain symbol.
                        state    <= DRAIN;
                        running  <= 1'b0;
                        symCount <= symTick ? 3'd1 : 3'd0;
                        if (symTick)
                            firSym <= '0;
                    end else if (symTick) begin
                        if (state == FLUSH) begin
                            firSym   <= '0;
                            symCount <= symCount + 3'd1;
                            if (symCount == 3'd7) begin
                                state   <= RUN;
                                running <= 1'b1;
                            end
                        end else if (modDataValid) begin
                            firSym <= dataSym;
                        end else begin
                            firSym    <= '0;
                            underflow <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (symTick) begin
                        firSym   <= '0;
                        symCount <= symCount + 3'd1;
                        if (symCount == 3'd7)
                            state <= enable ? FLUSH : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_soqpsk_mod_sequencer.sv
// Bench for soqpsk_mod_sequencer: vector table, multi-cycle corner sequences and a randomized model check.
// Expected symbols follow SOQPSK_PRECODE_EN in the same way as the design build.
module tb_soqpsk_mod_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] bitrateDivider = 16'd19;
    logic        modData = 1'b0;
    logic        modDataValid = 1'b0;
    logic        clrStatus = 1'b0;
    logic        modClkOut;
    logic        firNd;
    logic [2:0]  firSym;
    logic        running;
    logic        underflow;

    soqpsk_mod_sequencer dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .bitrateDivider(bitrateDivider),
        .modData(modData),
        .modDataValid(modDataValid),
        .clrStatus(clrStatus),
        .modClkOut(modClkOut),
        .firNd(firNd),
        .firSym(firSym),
        .running(running),
        .underflow(underflow)
    );

`ifdef SOQPSK_PRECODE_EN
    localparam bit PRECODE = 1'b1;
`else
    localparam bit PRECODE = 1'b0;
`endif

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int lastNd = 0;

    typedef struct {
        bit d;
        bit v;
        bit clr;
        int symPre;
        int symBin;
        int uf;
    } vecT;
    vecT vecs[13];

    // Reference model state: a[k-1], a[k-2] as +1/-1, symbol index k, sticky underflow.
    int mA1, mA2, mK, ufM;

    function automatic int modelSym(input bit d, input bit v);
        int a;
        int s;
        if (!v) return 0;
        a = d ? 1 : -1;
        if (!PRECODE) return a;
        s = (mK % 2 == 1) ? 1 : -1;
        s = s * mA1 * (a - mA2) / 2;
        mA2 = mA1;
        mA1 = a;
        mK = mK + 1;
        return s;
    endfunction

    function automatic int symVal();
        logic signed [2:0] s;
        s = firSym;
        return int'(s);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic waitNd(input int budget, output int gap);
        gap = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (firNd) begin
                gap = int'(cyc) - lastNd;
                lastNd = int'(cyc);
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL ndTimeout: got no firNd within %0d cycles expected a pulse", budget);
    endtask

    task automatic quietCheck(input string name, input int cycles);
        int nd;
        int hi;
        nd = 0;
        hi = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (firNd) nd++;
            if (modClkOut) hi++;
        end
        chk({name, "Nd"}, nd, 0);
        chk({name, "Clk"}, hi, 0);
    endtask

    task automatic resetPulse();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic flushPhase(input int period, input bit gapKnown);
        int gap;
        for (int i = 1; i <= 8; i++) begin
            waitNd(period + 4, gap);
            if (i > 1 || gapKnown) chk($sformatf("flushGapR%0d", i), gap, period);
            chk($sformatf("flushSymR%0d", i), symVal(), 0);
            chk($sformatf("flushClkR%0d", i), modClkOut, 1);
            chk($sformatf("flushRunR%0d", i), running, (i == 8) ? 1 : 0);
            waitNd(period + 4, gap);
            chk($sformatf("flushGapF%0d", i), gap, period);
            chk($sformatf("flushSymF%0d", i), symVal(), 0);
            chk($sformatf("flushClkF%0d", i), modClkOut, 0);
        end
    endtask

    // Called just after a falling-edge firNd pulse; one full bit period follows.
    task automatic doSymbol(input string name, input int idx, input bit d, input bit v, input bit clr,
                            input int expSym, input int expUf, input int period);
        int gap;
        modData = d;
        modDataValid = v;
        clrStatus = clr;
        waitNd(period + 4, gap);
        clrStatus = 1'b0;
        chk($sformatf("%s%0dGapR", name, idx), gap, period);
        chk($sformatf("%s%0dSym", name, idx), symVal(), expSym);
        chk($sformatf("%s%0dClkR", name, idx), modClkOut, 1);
        chk($sformatf("%s%0dUf", name, idx), underflow, expUf);
        waitNd(period + 4, gap);
        chk($sformatf("%s%0dGapF", name, idx), gap, period);
        chk($sformatf("%s%0dHold", name, idx), symVal(), expSym);
        chk($sformatf("%s%0dClkF", name, idx), modClkOut, 0);
    endtask

    task automatic drainPhase(input int period, input bit reEnable, input int expUf);
        int gap;
        enable = 1'b0;
        modDataValid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (reEnable && i == 4) enable = 1'b1;
            waitNd(period + 4, gap);
            chk($sformatf("drainGapR%0d", i), gap, period);
            chk($sformatf("drainSym%0d", i), symVal(), 0);
            chk($sformatf("drainClkR%0d", i), modClkOut, 1);
            chk($sformatf("drainRun%0d", i), running, 0);
            chk($sformatf("drainUf%0d", i), underflow, expUf);
            if (i < 8) begin
                waitNd(period + 4, gap);
                chk($sformatf("drainGapF%0d", i), gap, period);
                chk($sformatf("drainClkF%0d", i), modClkOut, 0);
            end
        end
        if (reEnable) begin
            waitNd(period + 4, gap);
            chk("reflushGapF", gap, period);
            chk("reflushClkF", modClkOut, 0);
        end else begin
            @(negedge clk);
            chk("idleClk", modClkOut, 0);
            chk("idleRun", running, 0);
            quietCheck("idleAfterDrain", 5 * period);
        end
    endtask

    initial begin
        int gap;
        vecs[0]  = '{1'b1, 1'b1, 1'b0,  1,  1, 0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0,  1,  1, 0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0,  0,  1, 0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, -1, -1, 0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0,  0,  0, 1};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, -1, -1, 1};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, -1,  1, 1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0,  0, -1, 1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0,  1, -1, 1};
        vecs[9]  = '{1'b1, 1'b1, 1'b1,  1,  1, 0};
        vecs[10] = '{1'b0, 1'b0, 1'b1,  0,  0, 1};
        vecs[11] = '{1'b0, 1'b1, 1'b0,  0, -1, 1};
        vecs[12] = '{1'b1, 1'b1, 1'b1,  0,  1, 0};

        reset = 1'b0;
        enable = 1'b0;
        bitrateDivider = 16'd19;
        repeat (3) @(negedge clk);
        chk("rstClk", modClkOut, 0);
        chk("rstNd", firNd, 0);
        chk("rstSym", symVal(), 0);
        chk("rstRun", running, 0);
        chk("rstUf", underflow, 0);
        reset = 1'b1;
        quietCheck("idle", 30);

        enable = 1'b1;
        flushPhase(20, 1'b0);
        for (int i = 0; i < 13; i++)
            doSymbol("vec", i, vecs[i].d, vecs[i].v, vecs[i].clr,
                     PRECODE ? vecs[i].symPre : vecs[i].symBin, vecs[i].uf, 20);

        drainPhase(20, 1'b1, 0);
        flushPhase(20, 1'b1);
        doSymbol("reflush", 0, 1'b1, 1'b1, 1'b0, 1, 0, 20);
        doSymbol("reflush", 1, 1'b1, 1'b1, 1'b0, 1, 0, 20);

        repeat (3) @(negedge clk);
        enable = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("abortClk", modClkOut, 0);
        chk("abortNd", firNd, 0);
        chk("abortSym", symVal(), 0);
        chk("abortRun", running, 0);
        chk("abortUf", underflow, 0);
        quietCheck("abort", 60);

        enable = 1'b1;
        flushPhase(20, 1'b0);
        doSymbol("histInit", 0, 1'b1, 1'b1, 1'b0, 1, 0, 20);

        bitrateDivider = 16'd9;
        modData = 1'b0;
        modDataValid = 1'b1;
        waitNd(24, gap);
        chk("divOldGap", gap, 20);
        waitNd(24, gap);
        chk("divNewGap", gap, 10);
        drainPhase(10, 1'b0, 0);

        bitrateDivider = 16'd0;
        resetPulse();
        enable = 1'b1;
        flushPhase(2, 1'b0);
        doSymbol("div0", 0, 1'b0, 1'b1, 1'b0, PRECODE ? 0 : -1, 0, 2);

        for (int r = 0; r < 3; r++) begin
            int per;
            int dv;
            enable = 1'b0;
            clrStatus = 1'b0;
            dv = (r == 0) ? 1 : (r == 1) ? 0 : int'($urandom_range(2, 6));
            bitrateDivider = 16'(dv);
            per = (dv == 0) ? 2 : dv + 1;
            resetPulse();
            mA1 = -1;
            mA2 = -1;
            mK = 0;
            ufM = 0;
            enable = 1'b1;
            flushPhase(per, 1'b0);
            for (int n = 0; n < 30; n++) begin
                bit bd;
                bit bv;
                bit bc;
                int es;
                bd = 1'($urandom_range(0, 1));
                bv = ($urandom_range(0, 7) != 0);
                bc = ($urandom_range(0, 5) == 0);
                es = modelSym(bd, bv);
                ufM = bc ? (bv ? 0 : 1) : ((ufM != 0 || !bv) ? 1 : 0);
                doSymbol("rnd", r * 100 + n, bd, bv, bc, es, ufM, per);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion within time limit expected finish");
        $fatal(1, "time limit");
    end
endmodule
